// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding and control-bundle constants for the pipeline controller.
package pipe_ctrl_pkg;
  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT  = 2'd1;
  localparam logic [1:0] ST_IRQ_DRAIN = 2'd2;
  typedef struct packed {
    logic pcwr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_stall;
    logic idex_hold;
    logic exmem_hold;
    logic irq_take;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE = ctrl_t'(7'b1100000);
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID.
module hazard_detect (
  input  logic       memrd,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       use_rt,
  output logic       hazard
);
  assign hazard = memrd && ex_rt != 5'd0 && (ex_rt == id_rs || (use_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/freeze controller with memory-wait timeout and interrupt entry.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IDEX_MemRd,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UseRt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  input  logic             IRQ,
  output logic             PCWr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Stall,
  output logic             IDEX_Hold,
  output logic             EXMEM_Hold,
  output logic             IRQ_Take,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0] state, state_n;
  logic [WW-1:0] wcnt;
  logic pending, irq_q, lu_q, hazard, mw, tmo, run_rules, lu, take;
  ctrl_t c;
  hazard_detect u_hz (
    .memrd (IDEX_MemRd),
    .ex_rt (IDEX_Rt),
    .id_rs (IFID_Rs),
    .id_rt (IFID_Rt),
    .use_rt(IFID_UseRt),
    .hazard(hazard)
  );
  // lu_q masks the hazard for the cycle after a stall so a load-use bubble is a single cycle
  always_comb begin
    tmo = state == ST_MEM_WAIT && wcnt >= WW'(MEM_TIMEOUT);
    mw = state == ST_MEM_WAIT ? !MemReady && !tmo : MemReq && !MemReady;
    run_rules = !mw && state != ST_IRQ_DRAIN;
    lu = run_rules && !BranchTaken && hazard && !lu_q;
    take = run_rules && !BranchTaken && !lu && pending;
    c = CTRL_IDLE;
    c.pcwr = !(mw || lu);
    c.ifid_wr = !(mw || lu);
    c.ifid_flush = (run_rules && (BranchTaken || take)) || (state == ST_IRQ_DRAIN && !mw);
    c.idex_stall = run_rules && (BranchTaken || lu || take);
    c.idex_hold = mw;
    c.exmem_hold = mw;
    c.irq_take = take;
    c = reset ? c : CTRL_IDLE;
    state_n = mw ? ST_MEM_WAIT : take ? ST_IRQ_DRAIN : ST_RUN;
  end
  assign {PCWr, IFID_Wr, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold, IRQ_Take} = c;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
      wcnt <= '0;
      pending <= 1'b0;
      irq_q <= 1'b0;
      lu_q <= 1'b0;
      MemErr <= 1'b0;
      StallCnt <= '0;
    end else begin
      state <= state_n;
      wcnt <= (state == ST_MEM_WAIT && mw) ? wcnt + 1'b1 : '0;
      pending <= (pending && !take) || (IRQ && !irq_q);
      irq_q <= IRQ;
      lu_q <= lu;
      if (tmo) MemErr <= 1'b1;
      if (!c.pcwr && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed table vectors for the RUN-state rules plus multi-cycle freeze, timeout, IRQ and reset sequences.
module tb_pipe_ctrl;
  logic clk = 0, reset = 0;
  logic IDEX_MemRd = 0, IFID_UseRt = 0, BranchTaken = 0, MemReq = 0, MemReady = 0, IRQ = 0;
  logic [4:0] IDEX_Rt = 0, IFID_Rs = 0, IFID_Rt = 0;
  logic PCWr, IFID_Wr, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold, IRQ_Take, MemErr;
  logic [15:0] StallCnt;
  logic [6:0] outs;
  int checks = 0, errors = 0;
  typedef struct {
    string name;
    logic memrd;
    logic [4:0] ex_rt, rs, rt;
    logic usert, br;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[8];
  pipe_ctrl dut (
    .clk(clk), .reset(reset), .IDEX_MemRd(IDEX_MemRd), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs),
    .IFID_Rt(IFID_Rt), .IFID_UseRt(IFID_UseRt), .BranchTaken(BranchTaken), .MemReq(MemReq),
    .MemReady(MemReady), .IRQ(IRQ), .PCWr(PCWr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush),
    .IDEX_Stall(IDEX_Stall), .IDEX_Hold(IDEX_Hold), .EXMEM_Hold(EXMEM_Hold), .IRQ_Take(IRQ_Take),
    .MemErr(MemErr), .StallCnt(StallCnt)
  );
  always #5 clk = ~clk;
  assign outs = {PCWr, IFID_Wr, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold, IRQ_Take};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input string nm, input logic [6:0] e);
    @(negedge clk);
    chk(nm, 32'(outs), 32'(e));
    @(posedge clk);
    #1;
  endtask
  task automatic set_lu(input logic m, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt, input logic ur);
    IDEX_MemRd = m; IDEX_Rt = ert; IFID_Rs = rs; IFID_Rt = rt; IFID_UseRt = ur;
  endtask
  task automatic idle_in();
    set_lu(0, 0, 0, 0, 0);
    BranchTaken = 0; MemReq = 0; MemReady = 0; IRQ = 0;
  endtask
  task automatic do_reset();
    idle_in();
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask
  initial begin
    tbl[0] = '{"idle",         0, 0, 0, 0, 0, 0, 7'b1100000};
    tbl[1] = '{"lu_rs",        1, 5, 5, 0, 0, 0, 7'b0001000};
    tbl[2] = '{"lu_rt0",       1, 0, 0, 0, 0, 0, 7'b1100000};
    tbl[3] = '{"lu_rt",        1, 7, 3, 7, 1, 0, 7'b0001000};
    tbl[4] = '{"rt_unused",    1, 7, 3, 7, 0, 0, 7'b1100000};
    tbl[5] = '{"no_load",      0, 5, 5, 0, 0, 0, 7'b1100000};
    tbl[6] = '{"branch",       0, 0, 0, 0, 0, 1, 7'b1111000};
    tbl[7] = '{"branch_lu",    1, 5, 5, 0, 0, 1, 7'b1111000};
    reset = 0;
    MemReq = 1;
    cyc("reset_idle0", 7'b1100000);
    cyc("reset_idle1", 7'b1100000);
    chk("reset_stallcnt", 32'(StallCnt), 0);
    chk("reset_memerr", 32'(MemErr), 0);
    reset = 1;
    idle_in();
    for (int i = 0; i < 8; i++) begin
      set_lu(tbl[i].memrd, tbl[i].ex_rt, tbl[i].rs, tbl[i].rt, tbl[i].usert);
      BranchTaken = tbl[i].br;
      cyc(tbl[i].name, tbl[i].exp);
      idle_in();
      cyc("sep", 7'b1100000);
    end
    chk("tbl_stallcnt", 32'(StallCnt), 2);
    // held load-use inputs stall only once
    do_reset();
    set_lu(1, 5, 5, 0, 0);
    cyc("lu_once_1", 7'b0001000);
    cyc("lu_once_2", 7'b1100000);
    idle_in();
    chk("lu_once_cnt", 32'(StallCnt), 1);
    // three-cycle memory wait, branch and hazard ignored while frozen
    do_reset();
    MemReq = 1;
    cyc("mw0", 7'b0000110);
    BranchTaken = 1;
    set_lu(1, 5, 5, 0, 0);
    cyc("mw1", 7'b0000110);
    idle_in();
    MemReq = 1;
    cyc("mw2", 7'b0000110);
    MemReady = 1;
    cyc("mw_rel", 7'b1100000);
    idle_in();
    chk("mw_stallcnt", 32'(StallCnt), 3);
    chk("mw_memerr", 32'(MemErr), 0);
    // memory never ready: 16 frozen cycles, then abort
    do_reset();
    MemReq = 1;
    for (int i = 0; i < 16; i++) cyc("tmo_frz", 7'b0000110);
    cyc("tmo_rel", 7'b1100000);
    MemReq = 0;
    chk("tmo_memerr", 32'(MemErr), 1);
    chk("tmo_stallcnt", 32'(StallCnt), 16);
    for (int i = 0; i < 3; i++) cyc("post_tmo", 7'b1100000);
    chk("tmo_sticky", 32'(MemErr), 1);
    do_reset();
    chk("tmo_cleared", 32'(MemErr), 0);
    // IRQ latched during a wait is taken on release, then drained
    do_reset();
    MemReq = 1;
    cyc("irqmw0", 7'b0000110);
    IRQ = 1;
    cyc("irqmw1", 7'b0000110);
    IRQ = 0;
    cyc("irqmw2", 7'b0000110);
    MemReady = 1;
    cyc("irq_take", 7'b1111001);
    MemReq = 0;
    MemReady = 0;
    cyc("irq_drain", 7'b1110000);
    cyc("irq_once", 7'b1100000);
    // reset in the middle of a wait clears pending and counters
    do_reset();
    MemReq = 1;
    IRQ = 1;
    cyc("rmw0", 7'b0000110);
    IRQ = 0;
    cyc("rmw1", 7'b0000110);
    reset = 0;
    cyc("rst_in_mw", 7'b1100000);
    reset = 1;
    MemReq = 0;
    chk("rst_stallcnt", 32'(StallCnt), 0);
    cyc("rst_after", 7'b1100000);
    cyc("rst_nopend", 7'b1100000);
    // IRQ yields to load-use and branch
    do_reset();
    IRQ = 1;
    set_lu(1, 5, 5, 0, 0);
    cyc("irq_lu", 7'b0001000);
    set_lu(0, 0, 0, 0, 0);
    BranchTaken = 1;
    cyc("irq_br", 7'b1111000);
    BranchTaken = 0;
    cyc("irq_take2", 7'b1111001);
    cyc("irq_drain2", 7'b1110000);
    cyc("irq_level", 7'b1100000);
    idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
